mdio_controller: RTL and testbench

- Station-management (STA) side of the MDIO link; sits directly upstream of the MDIO receiver (PHY side).
- Accepts a 32-bit Basic MDIO frame word and a start strobe. Generates MDC and serialises the frame MSB-first onto MDIO_OUT.
- For read frames it releases the bus after the address field and deserialises the 16 data bits returned on MDIO_IN into RD_DATA.

---
 rtl/mdio_pkg.sv | 38 +++
 rtl/mdc_clk_div.sv | 43 ++++
 rtl/mdio_controller.sv | 162 ++++++++++++++++
 tb/tb_mdio_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame layout, opcodes and controller state encodings.
// The optional MDIO_PREAMBLE_EN build uses PREAMBLE_BITS and S_PREAMBLE.
package mdio_pkg;

    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] ST_CLAUSE22 = 2'b01;

    localparam int ST_MSB      = 31;
    localparam int OP_MSB      = 29;
    localparam int PHYADDR_MSB = 27;
    localparam int REGADDR_MSB = 22;
    localparam int TA_MSB      = 17;
    localparam int DATA_MSB    = 15;

    localparam int ADDR_BITS     = 14;
    localparam int TA_BITS       = 2;
    localparam int FRAME_BITS    = 32;
    localparam int PREAMBLE_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_ADDR     = 3'd2,
        S_WRITE    = 3'd3,
        S_READ     = 3'd4,
        S_DONE     = 3'd5
    } mdio_state_e;

    function automatic logic [1:0] frame_op(input logic [FRAME_BITS-1:0] word);
        return word[OP_MSB -: 2];
    endfunction

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/mdc_clk_div.sv
// Free-running MDC generator: MDC toggles every CLK_DIV cycles, with
// single-cycle ticks flagging the CLK cycle in which MDC falls or rises.
module mdc_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic mdc_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          mdc_q;
    logic          mdc_d;
    logic          term;

    always_comb begin
        term  = (div_q == DIV_LAST);
        div_d = term ? '0 : div_q + DW'(1);
        mdc_d = term ? ~mdc_q : mdc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            div_q <= div_d;
            mdc_q <= mdc_d;
        end
    end

    // Ticks are combinational so the FSM updates on the same edge MDC toggles.
    assign mdc_o       = mdc_q;
    assign fall_tick_o = term & mdc_q;
    assign rise_tick_o = term & ~mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-management controller: serialises Clause-22 frames and captures
// read data. Define MDIO_PREAMBLE_EN to prepend a 32-bit all-ones preamble.
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        MDIO_DONE,
    output logic        BUSY
);

    localparam logic [5:0] CNT_ADDR_LAST  = 6'(ADDR_BITS - 1);
    localparam logic [5:0] CNT_FRAME      = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_DATA_FIRST = 6'(ADDR_BITS + TA_BITS + 1);

    logic fall_tick;
    logic rise_tick;

    mdio_state_e            state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [5:0]             bit_cnt_q;
    logic [5:0]             bit_cnt_d;
    logic                   is_rd_q;
    logic                   out_q;
    logic                   oe_q;
    logic [15:0]            rd_data_q;
    logic                   rdy_q;
    logic                   done_q;
    logic                   busy_q;
`ifdef MDIO_PREAMBLE_EN
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);
    logic [5:0]             pre_cnt_q;
`endif

    mdc_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_mdc_clk_div (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .mdc_o      (MDC),
        .fall_tick_o(fall_tick),
        .rise_tick_o(rise_tick)
    );

    assign bit_cnt_d = (bit_cnt_q == CNT_FRAME) ? bit_cnt_q : bit_cnt_q + 6'd1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            is_rd_q   <= 1'b0;
            out_q     <= 1'b0;
            oe_q      <= 1'b0;
            rd_data_q <= '0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
            pre_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            rdy_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MDIO_START && op_is_legal(frame_op(T_DATA))) begin
                        shift_q   <= T_DATA;
                        is_rd_q   <= (frame_op(T_DATA) == OP_READ);
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                        pre_cnt_q <= '0;
                        state_q   <= S_PREAMBLE;
`else
                        state_q   <= S_ADDR;
`endif
                    end
                end
`ifdef MDIO_PREAMBLE_EN
                S_PREAMBLE: begin
                    if (fall_tick) begin
                        out_q     <= 1'b1;
                        oe_q      <= 1'b1;
                        pre_cnt_q <= (pre_cnt_q == PRE_LAST) ? pre_cnt_q : pre_cnt_q + 6'd1;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_q <= S_ADDR;
                        end
                    end
                end
`endif
                S_ADDR: begin
                    if (fall_tick) begin
                        out_q     <= shift_q[FRAME_BITS-1];
                        oe_q      <= 1'b1;
                        shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == CNT_ADDR_LAST) begin
                            state_q <= is_rd_q ? S_READ : S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (fall_tick) begin
                        if (bit_cnt_q == CNT_FRAME) begin
                            out_q   <= 1'b0;
                            oe_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            out_q     <= shift_q[FRAME_BITS-1];
                            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                end
                S_READ: begin
                    // bit_cnt_q keeps counting MDC periods while the PHY owns the bus.
                    if (fall_tick) begin
                        out_q <= 1'b0;
                        oe_q  <= 1'b0;
                        if (bit_cnt_q == CNT_FRAME) begin
                            done_q  <= 1'b1;
                            rdy_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                    if (rise_tick && (bit_cnt_q >= CNT_DATA_FIRST)) begin
                        rd_data_q <= {rd_data_q[14:0], MDIO_IN};
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign MDIO_OUT  = out_q;
    assign MDIO_OE   = oe_q;
    assign RD_DATA   = rd_data_q;
    assign DATA_RDY  = rdy_q;
    assign MDIO_DONE = done_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller with a bus monitor and a small PHY
// read responder; honours MDIO_PREAMBLE_EN when the design is built with it.
`timescale 1ns/1ps
module tb_mdio_controller;

    localparam int CD     = 2;
    localparam int PERIOD = 2 * CD;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE_N = 32;
`else
    localparam int PRE_N = 0;
`endif
    localparam int BUDGET = (PRE_N + 33) * PERIOD + 20;

    logic        CLK        = 1'b0;
    logic        RESET      = 1'b1;
    logic        MDIO_START = 1'b0;
    logic [31:0] T_DATA     = '0;
    logic        MDIO_IN    = 1'b0;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        MDIO_DONE;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    mdio_controller #(
        .CLK_DIV(CD)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MDIO_START(MDIO_START),
        .T_DATA    (T_DATA),
        .MDIO_IN   (MDIO_IN),
        .MDC       (MDC),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .RD_DATA   (RD_DATA),
        .DATA_RDY  (DATA_RDY),
        .MDIO_DONE (MDIO_DONE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor state, owned by the always block below.
    bit          got_bits[$];
    int          cyc, done_cnt, rdy_cnt, rdy_with_done, align_err, oe_rises;
    int          busy_seen, busy_late, busy_cyc, done_cyc, mdc_period, last_rise, phy_fall;
    logic        busy_at_done;
    logic [15:0] rd_at_done;
    logic        prev_mdc, prev_out, prev_oe, prev_done;
    int          clr_ack = 0;

    // Stimulus-side state, owned by the initial block.
    int          clr_req = 0;
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = '0;
    bit          exp_bits[$];

    always @(negedge CLK) begin
        if (clr_req != clr_ack) begin
            clr_ack       <= clr_req;
            got_bits.delete();
            cyc           <= 0;
            done_cnt      <= 0;
            rdy_cnt       <= 0;
            rdy_with_done <= 0;
            align_err     <= 0;
            oe_rises      <= 0;
            busy_seen     <= 0;
            busy_late     <= 0;
            busy_cyc      <= 0;
            done_cyc      <= 0;
            mdc_period    <= 0;
            last_rise     <= -1;
            phy_fall      <= 0;
            busy_at_done  <= 1'b0;
            rd_at_done    <= '0;
            MDIO_IN       <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (MDC && !prev_mdc) begin
                if (MDIO_OE) got_bits.push_back(MDIO_OUT);
                if (last_rise >= 0) mdc_period <= cyc - last_rise;
                last_rise <= cyc;
            end
            if (RESET && ((MDIO_OUT !== prev_out) || (MDIO_OE !== prev_oe)) && !(prev_mdc && !MDC))
                align_err <= align_err + 1;
            if (MDIO_OE && !prev_oe) oe_rises <= oe_rises + 1;
            if (BUSY && busy_seen == 0) begin
                busy_seen <= 1;
                busy_cyc  <= cyc;
            end
            if (MDIO_DONE) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                busy_at_done <= BUSY;
                rd_at_done   <= RD_DATA;
                if (DATA_RDY) rdy_with_done <= rdy_with_done + 1;
            end
            if (DATA_RDY) rdy_cnt <= rdy_cnt + 1;
            if (prev_done && BUSY) busy_late <= busy_late + 1;
            // PHY: TA occupies the first two periods after release, then data MSB first.
            if (phy_en && prev_mdc && !MDC && !MDIO_OE && got_bits.size() >= PRE_N + 14) begin
                phy_fall <= phy_fall + 1;
                if (phy_fall >= 2 && phy_fall <= 17) MDIO_IN <= phy_data[17 - phy_fall];
            end
        end
        prev_mdc  <= MDC;
        prev_out  <= MDIO_OUT;
        prev_oe   <= MDIO_OE;
        prev_done <= MDIO_DONE;
    end

    task automatic clear_mon();
        clr_req = clr_req + 1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic pulse_start(input logic [31:0] w);
        T_DATA     = w;
        MDIO_START = 1'b1;
        @(negedge CLK);
        MDIO_START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic push_frame(input logic [31:0] w, input int nbits);
        for (int i = 0; i < PRE_N; i++) exp_bits.push_back(1'b1);
        for (int i = 0; i < nbits; i++) exp_bits.push_back(w[31 - i]);
    endtask

    function automatic logic [63:0] pack_got();
        logic [63:0] v;
        v = '0;
        foreach (got_bits[i]) v = {v[62:0], got_bits[i]};
        return v;
    endfunction

    function automatic logic [63:0] pack_exp();
        logic [63:0] v;
        v = '0;
        while (exp_bits.size() > 0) v = {v[62:0], exp_bits.pop_front()};
        return v;
    endfunction

    task automatic test_reset();
        RESET = 1'b0;
        #3;
        n_checks++;
        if ({MDC, MDIO_OUT, MDIO_OE, DATA_RDY, MDIO_DONE, BUSY} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {MDC, MDIO_OUT, MDIO_OE, DATA_RDY, MDIO_DONE, BUSY});
        end
        n_checks++;
        if (RD_DATA !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h, want 0000", RD_DATA);
        end
        @(negedge CLK);
        #2 RESET = 1'b1;
        clear_mon();
        repeat (4 * PERIOD) @(negedge CLK);
        n_checks++;
        if (mdc_period != PERIOD) begin
            n_fail++;
            $display("FAIL mdc_period: got %0d, want %0d", mdc_period, PERIOD);
        end
    endtask

    task automatic test_write();
        logic [63:0] g, e;
        int ne, lat;
        clear_mon();
        push_frame(32'h5A8A_BEEF, 32);
        ne = exp_bits.size();
        pulse_start(32'h5A8A_BEEF);
        wait_done(BUDGET);
        g = pack_got();
        e = pack_exp();
        n_checks++;
        if (got_bits.size() != ne) begin
            n_fail++;
            $display("FAIL wr_bit_count: got %0d, want %0d", got_bits.size(), ne);
        end
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL wr_frame: got %h, want %h", g, e);
        end
        n_checks++;
        if (g[15:0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL wr_data_rx: got %h, want beef", g[15:0]);
        end
        n_checks++;
        if (align_err != 0 || oe_rises != 1) begin
            n_fail++;
            $display("FAIL wr_drive_align: align_err=%0d oe_rises=%0d, want 0 and 1", align_err, oe_rises);
        end
        n_checks++;
        if (done_cnt != 1 || rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL wr_pulses: done=%0d rdy=%0d, want 1 and 0", done_cnt, rdy_cnt);
        end
        n_checks++;
        if (busy_at_done !== 1'b1 || busy_late != 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_busy: at_done=%b late=%0d now=%b, want 1 0 0", busy_at_done, busy_late, BUSY);
        end
        lat = done_cyc - busy_cyc;
        n_checks++;
        if (lat < (PRE_N + 32) * PERIOD || lat > (PRE_N + 33) * PERIOD + 1) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d cycles, want %0d..%0d", lat,
                     (PRE_N + 32) * PERIOD, (PRE_N + 33) * PERIOD + 1);
        end
    endtask

    task automatic test_read();
        logic [63:0] g, e;
        int ne;
        clear_mon();
        phy_data = 16'hC3A5;
        phy_en   = 1'b1;
        push_frame(32'h6822_0000, 14);
        ne = exp_bits.size();
        pulse_start(32'h6822_0000);
        wait_done(BUDGET);
        phy_en = 1'b0;
        g = pack_got();
        e = pack_exp();
        n_checks++;
        if (got_bits.size() != ne || g !== e) begin
            n_fail++;
            $display("FAIL rd_addr_bits: got %0d bits %h, want %0d bits %h", got_bits.size(), g, ne, e);
        end
        n_checks++;
        if (oe_rises != 1 || align_err != 0) begin
            n_fail++;
            $display("FAIL rd_oe: oe_rises=%0d align_err=%0d, want 1 and 0", oe_rises, align_err);
        end
        n_checks++;
        if (rd_at_done !== 16'hC3A5) begin
            n_fail++;
            $display("FAIL rd_data: got %h, want c3a5", rd_at_done);
        end
        n_checks++;
        if (done_cnt != 1 || rdy_cnt != 1 || rdy_with_done != 1) begin
            n_fail++;
            $display("FAIL rd_pulses: done=%0d rdy=%0d coincident=%0d, want 1 1 1", done_cnt, rdy_cnt, rdy_with_done);
        end
        n_checks++;
        if (RD_DATA !== 16'hC3A5 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_hold: rd_data=%h busy=%b, want c3a5 0", RD_DATA, BUSY);
        end
    endtask

    task automatic test_illegal_op();
        clear_mon();
        pulse_start(32'h7000_0000);
        repeat (6 * PERIOD) @(negedge CLK);
        n_checks++;
        if (busy_seen != 0 || oe_rises != 0 || done_cnt != 0 || rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL illegal_op: busy=%0d oe=%0d done=%0d rdy=%0d, want all 0",
                     busy_seen, oe_rises, done_cnt, rdy_cnt);
        end
        n_checks++;
        if (RD_DATA !== 16'hC3A5) begin
            n_fail++;
            $display("FAIL illegal_rd_hold: got %h, want c3a5", RD_DATA);
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] g, e;
        int ne;
        clear_mon();
        push_frame(32'h5A8A_BEEF, 32);
        ne = exp_bits.size();
        pulse_start(32'h5A8A_BEEF);
        repeat (10 * PERIOD) @(negedge CLK);
        pulse_start(32'h6822_0000);
        wait_done(BUDGET);
        g = pack_got();
        e = pack_exp();
        n_checks++;
        if (got_bits.size() != ne || g !== e) begin
            n_fail++;
            $display("FAIL busy_start_frame: got %0d bits %h, want %0d bits %h", got_bits.size(), g, ne, e);
        end
        n_checks++;
        if (done_cnt != 1 || rdy_cnt != 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_pulses: done=%0d rdy=%0d busy=%b, want 1 0 0", done_cnt, rdy_cnt, BUSY);
        end
        n_checks++;
        if (RD_DATA !== 16'hC3A5) begin
            n_fail++;
            $display("FAIL write_keeps_rd_data: got %h, want c3a5", RD_DATA);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] g, e;
        int ne;
        clear_mon();
        pulse_start(32'h5A8A_BEEF);
        repeat (12 * PERIOD) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        n_checks++;
        if ({MDC, MDIO_OUT, MDIO_OE, DATA_RDY, MDIO_DONE, BUSY} !== 6'b0 || RD_DATA !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b rd=%h, want 000000 rd=0000",
                     {MDC, MDIO_OUT, MDIO_OE, DATA_RDY, MDIO_DONE, BUSY}, RD_DATA);
        end
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (done_cnt != 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: done=%0d busy=%b, want 0 0", done_cnt, BUSY);
        end
        clear_mon();
        push_frame(32'h5A8A_1234, 32);
        ne = exp_bits.size();
        pulse_start(32'h5A8A_1234);
        wait_done(BUDGET);
        g = pack_got();
        e = pack_exp();
        n_checks++;
        if (got_bits.size() != ne || g !== e || done_cnt != 1) begin
            n_fail++;
            $display("FAIL after_reset_frame: got %0d bits %h done=%0d, want %0d bits %h done=1",
                     got_bits.size(), g, done_cnt, ne, e);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal_op();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
